kuuga_mem_port_adapter: RTL and testbench
=========================================

# kuuga_mem_port_adapter

Bridges a core-side req/gnt/rvalid memory port (instruction or data) to a single-port block RAM with one-cycle read latency. Converts byte addresses to word addresses, optionally inserts programmable wait states before grant to emulate slower memory, flags out-of-range accesses, and counts stall cycles for trace analysis. One instance sits between the core and each of the instruction and data BRAMs.

## Interface
- ADDR_WIDTH, 16, BRAM word-address width; byte space is 2^(ADDR_WIDTH+2) bytes
- WAIT_CYCLES, 0, wait states inserted before each grant (0..15)
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on an out-of-range access
---
- clk  in  1  single clock for the core port and the BRAM port
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  1  core request; held until granted
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid; one pulse per grant
- rdata_o  out  32  read data; 0 when rvalid_o is low
- err_o  out  1  out-of-range flag, qualified by rvalid_o
- stall_cnt_o  out  32  saturating count of cycles with req_i=1 and gnt_o=0
- bram_en_o  out  1  BRAM enable
- bram_we_o  out  4  BRAM byte write enables
- bram_addr_o  out  ADDR_WIDTH  BRAM word address
- bram_wdata_o  out  32  BRAM write data
- bram_rdata_i  in  32  BRAM read data; valid one cycle after en

## Operation
- FSM states: IDLE and WAIT. Wait counter `wcnt` is 4 bits.
- IDLE, req_i=1:
  - WAIT_CYCLES=0: grant combinationally this cycle.
  - Otherwise: load wcnt=WAIT_CYCLES-1, go to WAIT, no grant.
- WAIT:
  - req_i=1 and wcnt≠0: decrement wcnt.
  - req_i=1 and wcnt=0: gnt_o=1, return to IDLE.
  - req_i=0: return to IDLE, clear wcnt, no access issued.
- Grant cycle:
  - addr_i, we_i, be_i and wdata_i are sampled only in this cycle; changes while in WAIT have no effect.
  - In range (addr_i[31:ADDR_WIDTH+2]=0): bram_en_o=1, bram_addr_o=addr_i[ADDR_WIDTH+1:2], bram_we_o = we_i ? be_i : 4'b0, bram_wdata_o=wdata_i.
  - Out of range: bram_en_o=0 and bram_we_o=0; the BRAM is not touched.
- addr_i[1:0] is ignored. Byte lanes are selected only by be_i.
- Response, the cycle after the grant:
  - rvalid_o=1 for both reads and writes.
  - Read, in range: rdata_o=bram_rdata_i.
  - Write: rdata_o=0.
  - Out of range: err_o=1 and rdata_o=ERR_RDATA (reads) or 0 (writes).
  - A registered pending flag and a registered err bit drive this response.
- Outside grant cycles: bram_en_o=0, bram_we_o=0, and bram_addr_o/bram_wdata_o=0.
- stall_cnt_o increments by 1 each cycle with req_i=1 and gnt_o=0. It saturates at 32'hFFFF_FFFF and never wraps.

## Timing
- Reset values: FSM=IDLE, wcnt=0, pending=0, rvalid_o=0, err_o=0, rdata_o=0, stall_cnt_o=0, gnt_o=0, all bram_* outputs 0.
- Latency from request to grant: 0 cycles when WAIT_CYCLES=0, otherwise WAIT_CYCLES cycles.
- Latency from grant to rvalid_o: exactly 1 cycle.
- WAIT_CYCLES=0 sustains one access per cycle. The response to request N is presented in the same cycle that request N+1 is granted.
- With WAIT_CYCLES=W>0, back-to-back requests complete one per W+1 cycles. A new request may enter WAIT in the cycle its predecessor's rvalid_o is high.
- Reset asserted mid-transaction:
  - Any pending response is dropped, with no rvalid_o.
  - bram_en_o and bram_we_o fall to 0 asynchronously.
  - After reset releases, the core must re-issue the request.

## Structure
- Package kuuga_mem_pkg holds:
  - the state enum {IDLE, WAIT}
  - the default ERR_RDATA constant
  - the 32-bit saturation limit
- Sub-module kuuga_sat_counter (parameter WIDTH, inputs inc and clr, async active-low reset) implements stall_cnt_o.
- The FSM, wait counter, address decode and response register stay in the top module.

## Test plan
- WAIT_CYCLES=0, BRAM word 0x10 = 0xCAFEF00D:
  - Stimulus: read addr_i=0x40.
  - Required: gnt_o in the same cycle, bram_addr_o=0x10, rvalid_o next cycle, rdata_o=0xCAFEF00D, err_o=0, stall_cnt_o=0.
- WAIT_CYCLES=3, single write:
  - Stimulus: write addr_i=0x8, be_i=4'b0010, wdata_i=0x0000AB00.
  - Required: gnt_o on the 4th cycle of req_i, bram_we_o=4'b0010 at bram_addr_o=0x2, rvalid_o one cycle later, stall_cnt_o=3.
- WAIT_CYCLES=0, back-to-back reads:
  - Stimulus: 4 consecutive reads at 0x0, 0x4, 0x8, 0xC.
  - Required: 4 consecutive gnt_o cycles and 4 consecutive rvalid_o cycles with data in order.
- ADDR_WIDTH=16, out-of-range read:
  - Stimulus: read addr_i=0x0004_0000.
  - Required: gnt_o=1 with bram_en_o=0, then rvalid_o=1, err_o=1, rdata_o=0xDEADBEEF.
- WAIT_CYCLES=5, abandoned request:
  - Stimulus: drop req_i after 2 cycles in WAIT, then issue a new request.
  - Required: no gnt_o and no BRAM access for the dropped request; the new request waits the full 5 cycles.
- Reset during a response:
  - Stimulus: pull rst_n low in the cycle after a grant.
  - Required: rvalid_o=0, stall_cnt_o=0, all bram_* outputs 0, and the first access after release behaves as in the first scenario.

Source files
------------

// File: rtl/kuuga_mem_pkg.sv
// Shared types and constants for the core-to-BRAM memory port adapter.
package kuuga_mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [31:0] STALL_SAT_LIMIT   = 32'hFFFF_FFFF;

endpackage

// File: rtl/kuuga_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module kuuga_sat_counter #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/kuuga_mem_port_adapter.sv
// Bridges a core req/gnt/rvalid port to a one-cycle-latency single-port BRAM,
// with optional wait states, out-of-range detection and a stall counter.
module kuuga_mem_port_adapter
  import kuuga_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  bram_en_o,
  output logic [3:0]            bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [31:0]           bram_wdata_o,
  input  logic [31:0]           bram_rdata_i
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       wr_q, wr_d;
  logic       gnt;
  logic       in_range;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          gnt     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Gating with rst_n keeps grant and BRAM strobes low while reset is held.
    gnt = gnt & rst_n;
  end

  always_comb begin
    in_range     = ((addr_i >> (ADDR_WIDTH + 2)) == 32'd0);
    gnt_o        = gnt;
    bram_en_o    = 1'b0;
    bram_we_o    = '0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    if (gnt && in_range) begin
      bram_en_o    = 1'b1;
      bram_we_o    = we_i ? be_i : 4'b0000;
      bram_addr_o  = addr_i[ADDR_WIDTH+1:2];
      bram_wdata_o = wdata_i;
    end
    pend_d = gnt;
    err_d  = gnt && !in_range;
    wr_d   = gnt && we_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    rvalid_o = pend_q;
    err_o    = pend_q && err_q;
    rdata_o  = '0;
    if (pend_q && !wr_q) begin
      rdata_o = err_q ? ERR_RDATA : bram_rdata_i;
    end
  end

  kuuga_sat_counter #(
    .WIDTH (32),
    .LIMIT (STALL_SAT_LIMIT)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (req_i && !gnt),
    .clr     (1'b0),
    .count_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_kuuga_mem_port_adapter.sv
// Bench for kuuga_mem_port_adapter: three instances (0, 3 and 5 wait states)
// against a request-age reference model, plus directed literal checks.
module tb_kuuga_mem_port_adapter;

  localparam int unsigned WS [3] = '{0, 3, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [3];
  logic        we [3];
  logic [3:0]  be [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic        err [3];
  logic [31:0] rdata [3];
  logic [31:0] stall [3];
  logic        ben [3];
  logic [3:0]  bwe [3];
  logic [15:0] badr [3];
  logic [31:0] bwd [3];
  logic [31:0] brd [3];

  bit [31:0]   mem  [3][1024];
  bit [31:0]   gold [3][1024];

  int unsigned age [3];
  logic        m_rv [3];
  logic        m_err [3];
  logic [31:0] m_rd [3];
  logic [31:0] m_stall [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic       s_inc = 1'b0;
  logic       s_clr = 1'b0;
  logic [2:0] s_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    kuuga_mem_port_adapter #(
      .ADDR_WIDTH  (16),
      .WAIT_CYCLES (WS[g]),
      .ERR_RDATA   (32'hDEAD_BEEF)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req[g]),
      .gnt_o        (gnt[g]),
      .addr_i       (addr[g]),
      .we_i         (we[g]),
      .be_i         (be[g]),
      .wdata_i      (wdata[g]),
      .rvalid_o     (rvalid[g]),
      .rdata_o      (rdata[g]),
      .err_o        (err[g]),
      .stall_cnt_o  (stall[g]),
      .bram_en_o    (ben[g]),
      .bram_we_o    (bwe[g]),
      .bram_addr_o  (badr[g]),
      .bram_wdata_o (bwd[g]),
      .bram_rdata_i (brd[g])
    );
  end

  kuuga_sat_counter #(.WIDTH(3)) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (s_inc),
    .clr     (s_clr),
    .count_o (s_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // BRAM behavioural model: read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ben[i]) begin
        brd[i] <= mem[i][badr[i][9:0]];
        for (int k = 0; k < 4; k++)
          if (bwe[i][k]) mem[i][badr[i][9:0]][8*k +: 8] = bwd[i][8*k +: 8];
      end
    end
  end

  // Reference model: a request is granted once it has been held W cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic        eg, inr;
      logic [31:0] w;
      eg  = rst_n && req[i] && (age[i] == WS[i]);
      inr = (addr[i] < 32'h0004_0000);
      w   = addr[i] >> 2;
      chk($sformatf("i%0d gnt", i), 32'(gnt[i]), 32'(eg));
      chk($sformatf("i%0d bram_en", i), 32'(ben[i]), 32'(eg && inr));
      chk($sformatf("i%0d bram_we", i), 32'(bwe[i]), (eg && inr && we[i]) ? 32'(be[i]) : 32'd0);
      chk($sformatf("i%0d bram_addr", i), 32'(badr[i]), (eg && inr) ? {16'd0, w[15:0]} : 32'd0);
      chk($sformatf("i%0d bram_wdata", i), bwd[i], (eg && inr) ? wdata[i] : 32'd0);
      chk($sformatf("i%0d rvalid", i), 32'(rvalid[i]), 32'(rst_n && m_rv[i]));
      chk($sformatf("i%0d err", i), 32'(err[i]), 32'(rst_n && m_err[i]));
      chk($sformatf("i%0d rdata", i), rdata[i], rst_n ? m_rd[i] : 32'd0);
      chk($sformatf("i%0d stall", i), stall[i], rst_n ? m_stall[i] : 32'd0);
      if (!rst_n) begin
        age[i] = 0; m_rv[i] = 1'b0; m_err[i] = 1'b0; m_rd[i] = '0; m_stall[i] = '0;
      end else begin
        m_rv[i]  = eg;
        m_err[i] = eg && !inr;
        m_rd[i]  = (!eg || we[i]) ? 32'd0 : (inr ? gold[i][w[9:0]] : 32'hDEAD_BEEF);
        if (eg && inr && we[i])
          for (int k = 0; k < 4; k++)
            if (be[i][k]) gold[i][w[9:0]][8*k +: 8] = wdata[i][8*k +: 8];
        if (req[i] && !eg && m_stall[i] != 32'hFFFF_FFFF) m_stall[i] = m_stall[i] + 1;
        age[i] = (req[i] && !eg) ? age[i] + 1 : 0;
      end
    end
  end

  task automatic do_req(input int i, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int n, output logic [15:0] ga,
                        output logic ge, output logic [3:0] gw);
    req[i] = 1'b1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
    n = 0; ga = '0; ge = 1'b0; gw = '0;
    forever begin
      @(negedge clk);
      if (gnt[i]) begin
        ga = badr[i]; ge = ben[i]; gw = bwe[i];
        break;
      end
      n++;
      if (n > 40) begin
        fails++;
        tests++;
        $display("FAIL i%0d grant timeout: got none expected within 40 cycles", i);
        break;
      end
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    int          n, c0;
    logic [15:0] ga;
    logic        ge;
    logic [3:0]  gw;

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'hF; addr[i] = '0; wdata[i] = '0;
      age[i] = 0; m_stall[i] = '0;
      for (int k = 0; k < 1024; k++) begin mem[i][k] = '0; gold[i][k] = '0; end
    end
    mem[0][16] = 32'hCAFE_F00D; gold[0][16] = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      mem[0][k] = 32'h1111_1111 * (k + 1); gold[0][k] = 32'h1111_1111 * (k + 1);
    end
    mem[1][2] = 32'h1234_5678; gold[1][2] = 32'h1234_5678;
    mem[1][3] = 32'h0BAD_C0DE; gold[1][3] = 32'h0BAD_C0DE;
    mem[2][1] = 32'h5A5A_5A5A; gold[2][1] = 32'h5A5A_5A5A;

    // Reset state, with a request held to show grant stays low.
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 32'(gnt[0]), 32'd0);
    chk("reset bram_en", 32'(ben[0]), 32'd0);
    chk("reset rvalid", 32'(rvalid[0]), 32'd0);
    chk("reset stall", stall[0], 32'd0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Saturating counter boundary on a 3-bit instance.
    s_inc = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("sat count 6", 32'(s_cnt), 32'd6);
    repeat (3) @(posedge clk);
    #1 chk("sat hold at 7", 32'(s_cnt), 32'd7);
    s_clr = 1'b1;
    @(posedge clk);
    #1 chk("sat clear", 32'(s_cnt), 32'd0);
    s_inc = 1'b0; s_clr = 1'b0;

    // W=0 single read.
    do_req(0, 32'h40, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("w0 latency", 32'(n), 32'd0);
    chk("w0 bram_addr", 32'(ga), 32'h10);
    chk("w0 rvalid", 32'(rvalid[0]), 32'd1);
    chk("w0 rdata", rdata[0], 32'hCAFE_F00D);
    chk("w0 stall", stall[0], 32'd0);

    // W=0 back-to-back reads.
    c0 = cyc;
    for (int k = 0; k < 4; k++) do_req(0, 32'(4 * k), 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("b2b cycles", 32'(cyc - c0), 32'd4);
    chk("b2b last rdata", rdata[0], 32'h4444_4444);

    // Out-of-range read and write.
    do_req(0, 32'h0004_0000, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("oor bram_en", 32'(ge), 32'd0);
    chk("oor err", 32'(err[0]), 32'd1);
    chk("oor rdata", rdata[0], 32'hDEAD_BEEF);
    do_req(0, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h1234_5678, n, ga, ge, gw);
    chk("oor wr we", 32'(gw), 32'd0);
    chk("oor wr rdata", rdata[0], 32'd0);

    // W=3 byte write, then read-back.
    do_req(1, 32'h8, 1'b1, 4'b0010, 32'h0000_AB00, n, ga, ge, gw);
    chk("w3 latency", 32'(n), 32'd3);
    chk("w3 bram_addr", 32'(ga), 32'h2);
    chk("w3 bram_we", 32'(gw), 32'b0010);
    chk("w3 stall", stall[1], 32'd3);
    chk("w3 wr rvalid", 32'(rvalid[1]), 32'd1);
    do_req(1, 32'h8, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("w3 readback", rdata[1], 32'h1234_AB78);

    // W=3 address changed mid-wait: the grant-cycle address is used.
    req[1] = 1'b1; addr[1] = 32'h8; we[1] = 1'b0;
    @(posedge clk); #1;
    do_req(1, 32'hC, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("w3 midwait latency", 32'(n), 32'd2);
    chk("w3 midwait rdata", rdata[1], 32'h0BAD_C0DE);

    // W=5 abandoned write, then a fresh read.
    req[2] = 1'b1; addr[2] = 32'h4; we[2] = 1'b1; be[2] = 4'hF; wdata[2] = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 req[2] = 1'b0;
    @(posedge clk); #1;
    do_req(2, 32'h4, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("w5 latency", 32'(n), 32'd5);
    chk("w5 rdata", rdata[2], 32'h5A5A_5A5A);
    chk("w5 stall", stall[2], 32'd8);

    // Reset in the response cycle.
    do_req(0, 32'h40, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    rst_n = 1'b0;
    #1;
    chk("rst rvalid", 32'(rvalid[0]), 32'd0);
    chk("rst stall w3", stall[1], 32'd0);
    chk("rst bram_en", 32'(ben[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(0, 32'h40, 1'b0, 4'hF, 32'd0, n, ga, ge, gw);
    chk("post-rst latency", 32'(n), 32'd0);
    chk("post-rst rdata", rdata[0], 32'hCAFE_F00D);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
